// File: rtl/dealer_cmd_responder.sv
// Dealer-side command endpoint: executes link commands against a strided 52-card deck,
// streams dealt cards as suit/rank beats and acknowledges each command exactly once.
module dealer_cmd_responder #(
    parameter int HAND_SIZE = 5,
    parameter int STRIDE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cr_cmd,
    input  logic       cr_cmdvld,
    output logic       cr_ack,
    input  logic [5:0] seed,
    output logic       card_vld,
    output logic [1:0] card_suit,
    output logic [3:0] card_rank,
    output logic [5:0] cards_left,
    output logic       hand_active,
    output logic       cmd_err,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] CMD_NOP       = 3'b000;
    localparam logic [2:0] CMD_NEW_HAND  = 3'b001;
    localparam logic [2:0] CMD_DEAL_ONE  = 3'b010;
    localparam logic [2:0] CMD_DEAL_HAND = 3'b011;
    localparam logic [2:0] CMD_FOLD      = 3'b100;
    localparam logic [5:0] HAND_CNT      = 6'(HAND_SIZE);
    localparam logic [6:0] STRIDE_W      = 7'(STRIDE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_DEAL = 3'd2,
        S_ACK  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] cmd_q;
    logic [5:0] pos;
    logic [5:0] beats_left;

    logic [1:0] cur_suit;
    logic [5:0] cur_off;
    logic [3:0] cur_rank;
    logic [6:0] pos_sum;
    logic [6:0] pos_wrap;
    logic [5:0] pos_next;
    logic [5:0] seed_mod;
    logic [5:0] deal_cnt;

    // Card index -> suit/rank without a divider: the deck is four 13-card runs.
    always_comb begin
        cur_suit = 2'd0;
        cur_off  = pos;
        if (pos >= 6'd39) begin
            cur_suit = 2'd3;
            cur_off  = pos - 6'd39;
        end else if (pos >= 6'd26) begin
            cur_suit = 2'd2;
            cur_off  = pos - 6'd26;
        end else if (pos >= 6'd13) begin
            cur_suit = 2'd1;
            cur_off  = pos - 6'd13;
        end
    end

    assign cur_rank  = cur_off[3:0] + 4'd2;
    assign pos_sum   = {1'b0, pos} + STRIDE_W;
    assign pos_wrap  = pos_sum - 7'd52;
    assign pos_next  = (pos_sum >= 7'd52) ? pos_wrap[5:0] : pos_sum[5:0];
    assign seed_mod  = (seed >= 6'd52) ? (seed - 6'd52) : seed;
    assign deal_cnt  = (cmd_q == CMD_DEAL_ONE) ? 6'd1 : HAND_CNT;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_q       <= CMD_NOP;
            pos         <= 6'd0;
            beats_left  <= 6'd0;
            cr_ack      <= 1'b0;
            card_vld    <= 1'b0;
            card_suit   <= 2'd0;
            card_rank   <= 4'd0;
            cards_left  <= 6'd52;
            hand_active <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cr_ack   <= 1'b0;
            card_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cr_cmdvld) begin
                        cmd_q <= cr_cmd;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state  <= S_ACK;
                    cr_ack <= 1'b1;
                    case (cmd_q)
                        CMD_NOP: cmd_err <= 1'b0;
                        CMD_NEW_HAND: begin
                            pos         <= seed_mod;
                            cards_left  <= 6'd52;
                            hand_active <= 1'b1;
                            cmd_err     <= 1'b0;
                        end
                        CMD_FOLD: begin
                            hand_active <= 1'b0;
                            cmd_err     <= 1'b0;
                        end
                        CMD_DEAL_ONE, CMD_DEAL_HAND: begin
                            if (!hand_active || (cards_left < deal_cnt)) begin
                                cmd_err <= 1'b1;
                            end else begin
                                // First beat leaves with the EXEC edge so beats start one cycle later.
                                cr_ack     <= 1'b0;
                                state      <= S_DEAL;
                                card_vld   <= 1'b1;
                                card_suit  <= cur_suit;
                                card_rank  <= cur_rank;
                                pos        <= pos_next;
                                cards_left <= cards_left - 6'd1;
                                beats_left <= deal_cnt - 6'd1;
                            end
                        end
                        default: cmd_err <= 1'b1;
                    endcase
                end
                S_DEAL: begin
                    if (beats_left != 6'd0) begin
                        card_vld   <= 1'b1;
                        card_suit  <= cur_suit;
                        card_rank  <= cur_rank;
                        pos        <= pos_next;
                        cards_left <= cards_left - 6'd1;
                        beats_left <= beats_left - 6'd1;
                    end else begin
                        cr_ack  <= 1'b1;
                        cmd_err <= 1'b0;
                        state   <= S_ACK;
                    end
                end
                S_ACK: state <= S_DROP;
                // Hold here until the sender releases valid so a held request is not re-run.
                S_DROP: begin
                    if (!cr_cmdvld) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dealer_cmd_responder.sv
// Directed bench for dealer_cmd_responder: latency, deal sequence, errors, full-deck
// permutation, held-valid drop behaviour and reset in the middle of a deal.
module tb_dealer_cmd_responder;

    logic       clk;
    logic       rst;
    logic [2:0] cr_cmd;
    logic       cr_cmdvld;
    logic       cr_ack;
    logic [5:0] seed;
    logic       card_vld;
    logic [1:0] card_suit;
    logic [3:0] card_rank;
    logic [5:0] cards_left;
    logic       hand_active;
    logic       cmd_err;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    logic       got_ack;
    int         ack_cyc;
    logic [5:0] beat_q[$];
    int         beat_cyc_q[$];
    logic [5:0] exp_q[$];

    dealer_cmd_responder #(.HAND_SIZE(5), .STRIDE(7)) dut (
        .clk(clk), .rst(rst), .cr_cmd(cr_cmd), .cr_cmdvld(cr_cmdvld), .cr_ack(cr_ack),
        .seed(seed), .card_vld(card_vld), .card_suit(card_suit), .card_rank(card_rank),
        .cards_left(cards_left), .hand_active(hand_active), .cmd_err(cmd_err),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake: cr_cmdvld rises with cr_cmd and stays high until cr_ack is seen.
    task automatic do_cmd(input logic [2:0] cmd, input logic [5:0] sd, input bit release_vld);
        beat_q.delete();
        beat_cyc_q.delete();
        got_ack = 1'b0;
        ack_cyc = 0;
        @(negedge clk);
        cr_cmd    = cmd;
        seed      = sd;
        cr_cmdvld = 1'b1;
        for (int k = 1; k <= 80 && !got_ack; k++) begin
            @(negedge clk);
            if (card_vld === 1'b1) begin
                beat_q.push_back({card_suit, card_rank});
                beat_cyc_q.push_back(k);
            end
            if (cr_ack === 1'b1) begin
                got_ack = 1'b1;
                ack_cyc = k;
            end
        end
        checks++;
        if (!got_ack) begin
            failures++;
            $display("FAIL ack_timeout cmd=%0d: no cr_ack seen, required within 80 cycles", cmd);
        end
        if (release_vld) begin
            cr_cmdvld = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cr_cmdvld = 1'b0;
        cr_cmd = 3'd0;
        seed = 6'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cr_ack, card_vld, card_suit, card_rank} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs ack/vld/suit/rank=%b required 0", {cr_ack, card_vld, card_suit, card_rank});
        end
        checks++;
        if ({cards_left, hand_active, cmd_err, state_dbg} !== {6'd52, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_status left=%0d active=%b err=%b state=%0d required 52/0/0/0",
                     cards_left, hand_active, cmd_err, state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_new_hand;
        do_cmd(3'b001, 6'd0, 1'b1);
        checks++;
        if (ack_cyc !== 2) begin
            failures++;
            $display("FAIL new_hand_latency ack_cycle=%0d required 2", ack_cyc);
        end
        checks++;
        if ({cmd_err, hand_active, cards_left} !== {1'b0, 1'b1, 6'd52} || beat_q.size() != 0) begin
            failures++;
            $display("FAIL new_hand_status err=%b active=%b left=%0d beats=%0d required 0/1/52/0",
                     cmd_err, hand_active, cards_left, beat_q.size());
        end
    endtask

    task automatic test_deal_hand;
        exp_q.delete();
        exp_q.push_back({2'd0, 4'd2});
        exp_q.push_back({2'd0, 4'd9});
        exp_q.push_back({2'd1, 4'd3});
        exp_q.push_back({2'd1, 4'd10});
        exp_q.push_back({2'd2, 4'd4});
        do_cmd(3'b011, 6'd0, 1'b1);
        checks++;
        if (beat_q.size() != 5) begin
            failures++;
            $display("FAIL deal_hand_beats count=%0d required 5", beat_q.size());
        end
        for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i] || beat_cyc_q[i] != i + 2) begin
                failures++;
                $display("FAIL deal_hand_card%0d got suit/rank=%0d/%0d at cycle %0d required %0d/%0d at cycle %0d",
                         i, beat_q[i][5:4], beat_q[i][3:0], beat_cyc_q[i], exp_q[i][5:4], exp_q[i][3:0], i + 2);
            end
        end
        checks++;
        if (ack_cyc != 7 || cards_left !== 6'd47 || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL deal_hand_ack ack_cycle=%0d left=%0d err=%b required 7/47/0", ack_cyc, cards_left, cmd_err);
        end
    endtask

    task automatic test_errors;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_cmd(3'b010, 6'd0, 1'b1);
        checks++;
        if (ack_cyc != 2 || cmd_err !== 1'b1 || beat_q.size() != 0 || cards_left !== 6'd52) begin
            failures++;
            $display("FAIL deal_no_hand ack_cycle=%0d err=%b beats=%0d left=%0d required 2/1/0/52",
                     ack_cyc, cmd_err, beat_q.size(), cards_left);
        end
        do_cmd(3'b000, 6'd0, 1'b1);
        checks++;
        if (cmd_err !== 1'b0 || ack_cyc != 2) begin
            failures++;
            $display("FAIL nop err=%b ack_cycle=%0d required 0/2", cmd_err, ack_cyc);
        end
        do_cmd(3'b110, 6'd0, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || beat_q.size() != 0 || cards_left !== 6'd52) begin
            failures++;
            $display("FAIL illegal_op err=%b beats=%0d left=%0d required 1/0/52", cmd_err, beat_q.size(), cards_left);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky err=%b required 1", cmd_err);
        end
        do_cmd(3'b001, 6'd0, 1'b1);
        do_cmd(3'b100, 6'd0, 1'b1);
        checks++;
        if (hand_active !== 1'b0 || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL fold active=%b err=%b required 0/0", hand_active, cmd_err);
        end
        do_cmd(3'b011, 6'd0, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || beat_q.size() != 0 || cards_left !== 6'd52) begin
            failures++;
            $display("FAIL deal_after_fold err=%b beats=%0d left=%0d required 1/0/52", cmd_err, beat_q.size(), cards_left);
        end
    endtask

    task automatic test_full_deck;
        bit seen [52];
        int dupes;
        int bad;
        int idx;
        dupes = 0;
        bad = 0;
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        do_cmd(3'b001, 6'd63, 1'b1);
        for (int n = 0; n < 52; n++) begin
            do_cmd(3'b010, 6'd0, 1'b1);
            if (beat_q.size() != 1 || cmd_err !== 1'b0) begin
                bad++;
            end else begin
                if (n == 0) begin
                    checks++;
                    if (beat_q[0] !== {2'd0, 4'd13}) begin
                        failures++;
                        $display("FAIL seed63_first got suit/rank=%0d/%0d required 0/13", beat_q[0][5:4], beat_q[0][3:0]);
                    end
                end
                if (beat_q[0][3:0] < 4'd2 || beat_q[0][3:0] > 4'd14) begin
                    bad++;
                end else begin
                    idx = int'(beat_q[0][5:4]) * 13 + int'(beat_q[0][3:0]) - 2;
                    if (seen[idx]) dupes++;
                    seen[idx] = 1'b1;
                end
            end
        end
        checks++;
        if (bad != 0 || dupes != 0) begin
            failures++;
            $display("FAIL full_deck_unique bad_deals=%0d duplicates=%0d required 0/0", bad, dupes);
        end
        checks++;
        if (cards_left !== 6'd0) begin
            failures++;
            $display("FAIL full_deck_left left=%0d required 0", cards_left);
        end
        do_cmd(3'b010, 6'd0, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || beat_q.size() != 0 || cards_left !== 6'd0) begin
            failures++;
            $display("FAIL empty_deck_deal err=%b beats=%0d left=%0d required 1/0/0", cmd_err, beat_q.size(), cards_left);
        end
    endtask

    task automatic test_held_valid;
        do_cmd(3'b001, 6'd0, 1'b1);
        do_cmd(3'b010, 6'd0, 1'b0);
        checks++;
        if (beat_q.size() != 1 || cards_left !== 6'd51) begin
            failures++;
            $display("FAIL held_first beats=%0d left=%0d required 1/51", beat_q.size(), cards_left);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (state_dbg !== 3'd4 || cr_ack !== 1'b0 || card_vld !== 1'b0) begin
                failures++;
                $display("FAIL held_drop%0d state=%0d ack=%b vld=%b required 4/0/0", c, state_dbg, cr_ack, card_vld);
            end
        end
        checks++;
        if (cards_left !== 6'd51) begin
            failures++;
            $display("FAIL held_no_reexec left=%0d required 51", cards_left);
        end
        cr_cmdvld = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL held_release state=%0d required 0", state_dbg);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_deal;
        int acks;
        acks = 0;
        do_cmd(3'b001, 6'd0, 1'b1);
        @(negedge clk);
        cr_cmd    = 3'b011;
        cr_cmdvld = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (card_vld !== 1'b1 || {card_suit, card_rank} !== {2'd1, 4'd3}) begin
            failures++;
            $display("FAIL mid_deal_beat3 vld=%b suit/rank=%0d/%0d required 1/1/3", card_vld, card_suit, card_rank);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cr_ack, card_vld, card_suit, card_rank, cards_left, hand_active, cmd_err, state_dbg}
            !== {1'b0, 1'b0, 2'd0, 4'd0, 6'd52, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL async_reset ack=%b vld=%b suit=%0d rank=%0d left=%0d active=%b err=%b state=%0d required all reset",
                     cr_ack, card_vld, card_suit, card_rank, cards_left, hand_active, cmd_err, state_dbg);
        end
        cr_cmdvld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cr_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL reset_no_ack acks=%0d required 0", acks);
        end
        do_cmd(3'b001, 6'd5, 1'b1);
        checks++;
        if (ack_cyc != 2 || cmd_err !== 1'b0 || hand_active !== 1'b1 || cards_left !== 6'd52) begin
            failures++;
            $display("FAIL post_reset_new ack_cycle=%0d err=%b active=%b left=%0d required 2/0/1/52",
                     ack_cyc, cmd_err, hand_active, cards_left);
        end
        do_cmd(3'b010, 6'd0, 1'b1);
        checks++;
        if (beat_q.size() != 1 || beat_q[0] !== {2'd0, 4'd7} || ack_cyc != 3) begin
            failures++;
            $display("FAIL post_reset_deal beats=%0d card=%0d/%0d ack_cycle=%0d required 1 card 0/7 ack 3",
                     beat_q.size(), beat_q[0][5:4], beat_q[0][3:0], ack_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_new_hand();
        test_deal_hand();
        test_errors();
        test_full_deck();
        test_held_valid();
        test_reset_mid_deal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dealer_cmd_responder.md
Name: dealer_cmd_responder

Overview:
Dealer-side endpoint of the card-room command link. Accepts 3-bit commands over the cr_cmd/cr_cmdvld/cr_ack handshake driven by the player-side command generator, and executes them against a 52-card deck. Deals cards as encoded suit/rank beats, then returns a one-cycle acknowledge. Also tracks hand state, remaining deck count and command errors.

Parameters:
HAND_SIZE, 5, cards dealt by DEAL_HAND (1..52)
STRIDE, 7, deck permutation step; must be coprime with 52 and less than 52

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cr_cmd  in  3  command code; valid while cr_cmdvld=1
cr_cmdvld  in  1  command valid; held high by the sender until cr_ack
cr_ack  out  1  one-cycle acknowledge, registered
seed  in  6  deck start offset, sampled on NEW_HAND
card_vld  out  1  card beat valid, one cycle per card
card_suit  out  2  0=clubs 1=diamonds 2=hearts 3=spades
card_rank  out  4  2..14 (14=ace)
cards_left  out  6  undealt cards in the deck, 0..52
hand_active  out  1  hand in progress
cmd_err  out  1  status of the last acknowledged command, held until the next ack

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, any state, including mid-deal) forces all outputs and state registers to the following values:
  - state=IDLE
  - cr_ack=0, card_vld=0, card_suit=0, card_rank=0
  - cards_left=52, hand_active=0, cmd_err=0
  - pos=0
  - No ack is issued for a command interrupted by reset.
- Command codes:
  - 000 NOP
  - 001 NEW_HAND
  - 010 DEAL_ONE
  - 011 DEAL_HAND
  - 100 FOLD
  - 101..111 illegal
- FSM states: IDLE, EXEC, DEAL, ACK, DROP. All outputs are registered.
- IDLE:
  - On an edge with cr_cmdvld=1 (the accept edge A), latch cr_cmd and go to EXEC.
- EXEC (one cycle):
  - NOP: no effect, err=0.
  - NEW_HAND: pos<=seed mod 52 (seed 52..63 maps to seed-52); cards_left<=52; hand_active<=1; err=0.
  - FOLD: hand_active<=0; err=0 even if no hand is active.
  - Illegal code: err=1.
  - DEAL_ONE / DEAL_HAND when hand_active=0, or when cards_left < count (1 or HAND_SIZE): err=1, nothing dealt.
  - All of the above go to ACK.
  - Valid deal: go to DEAL with the beat counter loaded to count.
- DEAL (one beat per cycle, no gaps):
  - card_vld=1; card index=pos.
  - suit=pos/13; rank=(pos mod 13)+2.
  - pos<=pos+STRIDE, minus 52 if the sum is ≥52.
  - cards_left decrements by 1 per beat.
  - After the last beat go to ACK with err=0.
- ACK:
  - cr_ack=1 for exactly one cycle; cmd_err updates in the same cycle; go to DROP.
- DROP:
  - Wait for cr_cmdvld=0, then go to IDLE.
  - Prevents a held cr_cmdvld from being re-accepted as a new command.
- Latency, relative to accept edge A:
  - Non-deal commands: cr_ack is high in the 2nd cycle after A.
  - Deals: card_vld is high in cycles 2..count+1 after A; cr_ack is high in cycle count+2.
- Permutation: a full 52-card deal visits every index exactly once, because gcd(STRIDE,52)=1.
- cr_cmdvld dropping before ack (protocol violation): the operation still completes and the ack is still issued; DROP exits immediately.
- cr_cmd changing mid-operation: ignored, because the command was latched at A.
- cmd_err is not cleared by subsequent idle cycles.

Test Plan:
- Reset, then NEW_HAND with seed=0 -> cr_ack in the 2nd cycle after accept; cmd_err=0; hand_active=1; cards_left=52; no card_vld.
- After NEW_HAND with seed=0, DEAL_HAND (STRIDE=7) -> exactly 5 consecutive card beats:
  - Expected (suit,rank) sequence: (0,2) (0,9) (1,3) (1,10) (2,4).
  - cr_ack comes in the cycle after the last beat; cards_left=47.
- DEAL_ONE before any NEW_HAND, and opcode 110 -> each is acked with cmd_err=1, no card_vld, cards_left unchanged.
- NEW_HAND with seed=63 (maps to 11), then 52×DEAL_ONE -> all 52 (suit,rank) pairs are unique, cards_left=0. A following DEAL_ONE is acked with cmd_err=1.
- Hold cr_cmdvld=1 for 4 cycles after the ack -> no second execution; the block stays in DROP until cr_cmdvld=0.
- Assert rst during the 3rd beat of DEAL_HAND -> all outputs go to reset values immediately; cr_ack never pulses for that command; the next NEW_HAND behaves normally.
